// File: rtl/motor_pwm_pkg.sv
// motor_pwm_pkg: shared types and constants for the two-channel H-bridge PWM driver
package motor_pwm_pkg;
    localparam int DUTY_W = 8;
    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;
    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
endpackage

// File: rtl/motor_pwm_channel.sv
// motor_pwm_channel: per-wheel FSM, dead-time counter, effective duty and registered bridge inputs
// STEP is the per-period duty slew limit; a STEP above full scale gives a plain step response
module motor_pwm_channel
    import motor_pwm_pkg::*;
#(
    parameter int DEADTIME_PERIODS = 2,
    parameter int STEP = 4
) (
    input  logic              PCLK,
    input  logic              PRESERN,
    input  logic              period_start,
    input  logic [DUTY_W-1:0] pwm_cnt,
    input  logic [DUTY_W-1:0] duty,
    input  logic              en,
    input  logic              dir,
    output logic              in_1,
    output logic              in_2,
    output logic [DUTY_W-1:0] eff_duty
);
    state_t state, state_n;
    logic cur_dir, dir_n, go, pwm;
    logic [7:0] dead_cnt, dead_n;
    logic [DUTY_W-1:0] eff_n;

    function automatic logic [DUTY_W-1:0] ramp(input logic [DUTY_W-1:0] cur, input logic [DUTY_W-1:0] tgt);
        int d;
        d = int'(tgt) - int'(cur);
        d = d > STEP ? STEP : d < -STEP ? -STEP : d;
        return DUTY_W'(int'(cur) + d);
    endfunction

    assign go = en && duty != '0;
    assign pwm = state == RUN && pwm_cnt < eff_duty;

    always_comb begin
        state_n = state;
        dir_n = cur_dir;
        dead_n = dead_cnt;
        eff_n = eff_duty;
        if (period_start) begin
            case (state)
                IDLE: if (go) begin
                    state_n = RUN;
                    dir_n = dir;
                    eff_n = ramp('0, duty);
                end
                RUN: if (!go) begin
                    state_n = IDLE;
                    eff_n = '0;
                end else if (dir != cur_dir) begin
                    state_n = DEAD;
                    dead_n = 8'(DEADTIME_PERIODS);
                    eff_n = '0;
                end else begin
                    eff_n = ramp(eff_duty, duty);
                end
                DEAD: begin
                    // the coast interval always runs to completion, whatever dir does meanwhile
                    dead_n = dead_cnt == '0 ? '0 : dead_cnt - 8'd1;
                    if (dead_n == '0) begin
                        state_n = go ? RUN : IDLE;
                        dir_n = go ? dir : cur_dir;
                        eff_n = go ? ramp('0, duty) : '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    eff_n = '0;
                end
            endcase
        end
    end

    // both bridge inputs derive from one registered cur_dir, so they can never be high together
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state <= IDLE;
            cur_dir <= DIR_FWD;
            dead_cnt <= '0;
            eff_duty <= '0;
            in_1 <= 1'b0;
            in_2 <= 1'b0;
        end else begin
            state <= state_n;
            cur_dir <= dir_n;
            dead_cnt <= dead_n;
            eff_duty <= eff_n;
            in_1 <= pwm && cur_dir == DIR_FWD;
            in_2 <= pwm && cur_dir == DIR_REV;
        end
    end
endmodule

// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: shared prescaler/PWM counter feeding right and left H-bridge channels
// Define MOTOR_RAMP_EN to slew-limit the effective duty by RAMP_STEP per period
module motor_pwm_driver
    import motor_pwm_pkg::*;
#(
    parameter int PRESCALE = 391,
    parameter int DEADTIME_PERIODS = 2,
    parameter int RAMP_STEP = 4
) (
    input  logic              PCLK,
    input  logic              PRESERN,
    input  logic [DUTY_W-1:0] PWM_DUTY_R,
    input  logic [DUTY_W-1:0] PWM_DUTY_L,
    input  logic              PWM_EN_R,
    input  logic              PWM_EN_L,
    input  logic              PWM_DIR_R,
    input  logic              PWM_DIR_L,
    output logic              MOTOR_R_IN1,
    output logic              MOTOR_R_IN2,
    output logic              MOTOR_L_IN1,
    output logic              MOTOR_L_IN2,
    output logic [DUTY_W-1:0] CUR_DUTY_R,
    output logic [DUTY_W-1:0] CUR_DUTY_L,
    output logic              PERIOD_TICK
);
`ifdef MOTOR_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif
    localparam int STEP = RAMP_EN ? RAMP_STEP : 256;
    localparam int PS_W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] psc;
    logic [DUTY_W-1:0] pwm_cnt;
    logic step, period_start;

    assign step = psc == PS_W'(PRESCALE - 1);
    assign period_start = step && pwm_cnt == '1;

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            psc <= '0;
            pwm_cnt <= '0;
            PERIOD_TICK <= 1'b0;
        end else begin
            psc <= step ? '0 : psc + PS_W'(1);
            pwm_cnt <= pwm_cnt + DUTY_W'(step);
            PERIOD_TICK <= period_start;
        end
    end

    motor_pwm_channel #(.DEADTIME_PERIODS(DEADTIME_PERIODS), .STEP(STEP)) u_r (
        .PCLK(PCLK), .PRESERN(PRESERN), .period_start(period_start), .pwm_cnt(pwm_cnt),
        .duty(PWM_DUTY_R), .en(PWM_EN_R), .dir(PWM_DIR_R),
        .in_1(MOTOR_R_IN1), .in_2(MOTOR_R_IN2), .eff_duty(CUR_DUTY_R)
    );

    motor_pwm_channel #(.DEADTIME_PERIODS(DEADTIME_PERIODS), .STEP(STEP)) u_l (
        .PCLK(PCLK), .PRESERN(PRESERN), .period_start(period_start), .pwm_cnt(pwm_cnt),
        .duty(PWM_DUTY_L), .en(PWM_EN_L), .dir(PWM_DIR_L),
        .in_1(MOTOR_L_IN1), .in_2(MOTOR_L_IN2), .eff_duty(CUR_DUTY_L)
    );
endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb_motor_pwm_driver: per-period scoreboard of bridge high times, duty readback and tick spacing
module tb_motor_pwm_driver;
`ifdef MOTOR_RAMP_EN
    localparam int STEP = 4;
`else
    localparam int STEP = 256;
`endif
    typedef struct {
        string tag;
        int r1, r2, l1, l2, cr, cl;
    } exp_t;

    logic PCLK, PRESERN;
    logic [7:0] PWM_DUTY_R, PWM_DUTY_L, CUR_DUTY_R, CUR_DUTY_L;
    logic PWM_EN_R, PWM_EN_L, PWM_DIR_R, PWM_DIR_L;
    logic MOTOR_R_IN1, MOTOR_R_IN2, MOTOR_L_IN1, MOTOR_L_IN2, PERIOD_TICK;

    exp_t q[$];
    exp_t cur;
    int n_cmp = 0, n_bad = 0;
    int e_r = 0, e_l = 0, t_r = 0, t_l = 0;
    bit run_r = 0, run_l = 0, dir_r = 0, dir_l = 0;
    int h_r1, h_r2, h_l1, h_l2, len, cap_r, cap_l;
    bit started = 0, have = 0, excl = 0, quiet = 0;

    motor_pwm_driver #(.PRESCALE(1), .DEADTIME_PERIODS(2), .RAMP_STEP(4)) dut (
        .PCLK(PCLK), .PRESERN(PRESERN),
        .PWM_DUTY_R(PWM_DUTY_R), .PWM_DUTY_L(PWM_DUTY_L),
        .PWM_EN_R(PWM_EN_R), .PWM_EN_L(PWM_EN_L),
        .PWM_DIR_R(PWM_DIR_R), .PWM_DIR_L(PWM_DIR_L),
        .MOTOR_R_IN1(MOTOR_R_IN1), .MOTOR_R_IN2(MOTOR_R_IN2),
        .MOTOR_L_IN1(MOTOR_L_IN1), .MOTOR_L_IN2(MOTOR_L_IN2),
        .CUR_DUTY_R(CUR_DUTY_R), .CUR_DUTY_L(CUR_DUTY_L),
        .PERIOD_TICK(PERIOD_TICK)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int nxt(input int e, input int t);
        int d;
        d = t - e;
        d = d > STEP ? STEP : d < -STEP ? -STEP : d;
        return e + d;
    endfunction

    task automatic wait_tick();
        int c = 0;
        do begin
            @(negedge PCLK);
            c++;
        end while (!PERIOD_TICK && c < 600);
        if (!PERIOD_TICK) chk("tick_timeout", 0, 1);
    endtask

    task automatic mid();
        repeat (100) @(negedge PCLK);
    endtask

    // n==0: push periods until every running channel reaches its target
    task automatic phase(input string tag, input int n);
        int k = 0;
        exp_t x;
        do begin
            e_r = run_r ? nxt(e_r, t_r) : 0;
            e_l = run_l ? nxt(e_l, t_l) : 0;
            x = '{tag, (run_r && !dir_r) ? e_r : 0, (run_r && dir_r) ? e_r : 0,
                  (run_l && !dir_l) ? e_l : 0, (run_l && dir_l) ? e_l : 0, e_r, e_l};
            q.push_back(x);
            k++;
        end while (n > 0 ? k < n : !((!run_r || e_r == t_r) && (!run_l || e_l == t_l)) && k < 100);
        for (int i = 0; i < k; i++) wait_tick();
        mid();
    endtask

    always @(negedge PCLK) begin
        if (!PRESERN) begin
            started = 0;
            have = 0;
            quiet = 0;
        end else begin
            if (PERIOD_TICK) begin
                if (have) begin
                    chk({cur.tag, ":r_in1"}, h_r1, cur.r1);
                    chk({cur.tag, ":r_in2"}, h_r2, cur.r2);
                    chk({cur.tag, ":l_in1"}, h_l1, cur.l1);
                    chk({cur.tag, ":l_in2"}, h_l2, cur.l2);
                    chk({cur.tag, ":cur_r"}, cap_r, cur.cr);
                    chk({cur.tag, ":cur_l"}, cap_l, cur.cl);
                    chk({cur.tag, ":period"}, len, 256);
                    chk({cur.tag, ":both_high"}, int'(excl), 0);
                end else if (!started) begin
                    chk("pre_tick_quiet", int'(quiet), 0);
                end
                started = 1;
                have = q.size() != 0;
                if (have) cur = q.pop_front();
                {h_r1, h_r2, h_l1, h_l2, len} = '0;
                excl = 0;
                cap_r = int'(CUR_DUTY_R);
                cap_l = int'(CUR_DUTY_L);
            end
            if (started) begin
                h_r1 += int'(MOTOR_R_IN1);
                h_r2 += int'(MOTOR_R_IN2);
                h_l1 += int'(MOTOR_L_IN1);
                h_l2 += int'(MOTOR_L_IN2);
                len++;
                excl |= (MOTOR_R_IN1 & MOTOR_R_IN2) | (MOTOR_L_IN1 & MOTOR_L_IN2);
            end else begin
                quiet |= MOTOR_R_IN1 | MOTOR_R_IN2 | MOTOR_L_IN1 | MOTOR_L_IN2 | (|CUR_DUTY_R) | (|CUR_DUTY_L);
            end
        end
    end

    initial begin
        {PWM_DUTY_R, PWM_DUTY_L, PWM_EN_R, PWM_EN_L, PWM_DIR_R, PWM_DIR_L} = '0;
        PRESERN = 1'b1;
        #2 PRESERN = 1'b0;
        #20;
        chk("rst_r_in", int'({MOTOR_R_IN1, MOTOR_R_IN2}), 0);
        chk("rst_l_in", int'({MOTOR_L_IN1, MOTOR_L_IN2}), 0);
        chk("rst_cur", int'({CUR_DUTY_R, CUR_DUTY_L}), 0);
        chk("rst_tick", int'(PERIOD_TICK), 0);
        #31 PRESERN = 1'b1;
        wait_tick();
        mid();
        phase("idle", 2);
        {PWM_EN_R, PWM_DIR_R, PWM_DUTY_R} = {1'b1, 1'b0, 8'd64};
        {run_r, dir_r, t_r} = {1'b1, 1'b0, 32'd64};
        phase("r64", 2);
        PWM_DUTY_R = 8'd128;
        t_r = 128;
        phase("r128", 0);
        PWM_DIR_R = 1'b1;
        run_r = 0;
        phase("r_dead", 2);
        {run_r, dir_r} = 2'b11;
        phase("r_rev", 2);
        {PWM_DUTY_R, PWM_DIR_R} = {8'd0, 1'b0};
        {run_r, dir_r, t_r} = {1'b0, 1'b0, 32'd0};
        phase("r_duty0", 1);
        PWM_DUTY_R = 8'd100;
        {run_r, t_r} = {1'b1, 32'd100};
        phase("r_up100", 0);
        PWM_DUTY_R = 8'd2;
        t_r = 2;
        phase("r_dn2", 0);
        {PWM_EN_L, PWM_DIR_L, PWM_DUTY_L} = {1'b1, 1'b0, 8'd255};
        {run_l, dir_l, t_l} = {1'b1, 1'b0, 32'd255};
        phase("l255", 0);
        phase("l255_hold", 1);
        {PWM_DUTY_L, PWM_DIR_L, PWM_DIR_R} = {8'd40, 1'b1, 1'b1};
        {run_r, run_l, t_l} = {1'b0, 1'b0, 32'd40};
        phase("dead_both", 2);
        {run_r, dir_r, run_l, dir_l} = 4'b1111;
        phase("rev_both", 0);
        {PWM_EN_L, PWM_DUTY_R} = {1'b0, 8'd160};
        {run_l, t_r} = {1'b0, 32'd160};
        phase("l_off_r160", 0);
        #2;
        chk("pre_arst_r_in2", int'(MOTOR_R_IN2), 1);
        PRESERN = 1'b0;
        #1;
        chk("arst_r_in", int'({MOTOR_R_IN1, MOTOR_R_IN2}), 0);
        chk("arst_cur_r", int'(CUR_DUTY_R), 0);
        chk("arst_tick", int'(PERIOD_TICK), 0);
        repeat (20) @(negedge PCLK);
        #2 PRESERN = 1'b1;
        {e_r, e_l} = '0;
        phase("post_rst", 2);
        wait_tick();
        repeat (2) @(negedge PCLK);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
